s2mm_cmd_sched: RTL and testbench

S2MM_CMD_SCHED -- requirements
Module: s2mm_cmd_sched

---
 rtl/s2mm_sched_pkg.sv | 33 +++
 rtl/s2mm_cmd_pack.sv | 23 ++
 rtl/s2mm_cmd_sched.sv | 175 +++++++++++++++++
 tb/tb_s2mm_cmd_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2mm_sched_pkg.sv
// Shared types and field positions for the S2MM datamover command scheduler.
// Command word layout follows the datamover S2MM 72-bit command format.
package s2mm_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam int CMD_W        = 72;
  localparam int CMD_BTT_LSB  = 0;
  localparam int CMD_BTT_W    = 23;
  localparam int CMD_TYPE_BIT = 23;
  localparam int CMD_DSA_LSB  = 24;
  localparam int CMD_DSA_W    = 6;
  localparam int CMD_EOF_BIT  = 30;
  localparam int CMD_DRR_BIT  = 31;
  localparam int CMD_ADDR_LSB = 32;
  localparam int CMD_TAG_LSB  = 64;
  localparam int CMD_TAG_W    = 4;
  localparam int CMD_RSVD_LSB = 68;

  localparam int STS_OKAY_BIT   = 7;
  localparam int STS_SLVERR_BIT = 6;
  localparam int STS_DECERR_BIT = 5;
  localparam int STS_INTERR_BIT = 4;

  localparam logic CMD_TYPE_INCR = 1'b1;

endpackage

// File: rtl/s2mm_cmd_pack.sv
// Combinational packer for one datamover S2MM command word.
module s2mm_cmd_pack
  import s2mm_sched_pkg::*;
(
  input  logic [CMD_BTT_W-1:0] btt,
  input  logic [31:0]          addr,
  input  logic [CMD_TAG_W-1:0] tag,
  output logic [CMD_W-1:0]     cmd
);

  always_comb begin
    cmd = '0;
    cmd[CMD_BTT_LSB +: CMD_BTT_W]             = btt;
    cmd[CMD_TYPE_BIT]                         = CMD_TYPE_INCR;
    cmd[CMD_DSA_LSB +: CMD_DSA_W]             = '0;
    cmd[CMD_EOF_BIT]                          = 1'b1;
    cmd[CMD_DRR_BIT]                          = 1'b0;
    cmd[CMD_ADDR_LSB +: 32]                   = addr;
    cmd[CMD_TAG_LSB +: CMD_TAG_W]             = tag;
    cmd[CMD_RSVD_LSB +: CMD_W - CMD_RSVD_LSB] = '0;
  end

endmodule

// File: rtl/s2mm_cmd_sched.sv
// Splits a capture ring into datamover S2MM commands, throttled by outstanding status.
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | presenting commands while credit allows
//   DRAIN | no new commands, waiting for all status
//   DONE  | one-cycle completion pulse
//   ERROR | failing status seen, held until clear
module s2mm_cmd_sched
  import s2mm_sched_pkg::*;
#(
  parameter int CHUNK_BYTES     = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              axis_st_clk,
  input  logic              axis_st_rstb,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              continuous,
  input  logic [31:0]       base_addr,
  input  logic [31:0]       cap_size,
  output logic [CMD_W-1:0]  m_axis_cmd_tdata,
  output logic              m_axis_cmd_tvalid,
  input  logic              m_axis_cmd_tready,
  input  logic [7:0]        s_axis_sts_tdata,
  input  logic              s_axis_sts_tvalid,
  output logic              s_axis_sts_tready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_status,
  output logic [15:0]       pass_count,
  output logic [3:0]        outstanding
);

  localparam logic [31:0] CHUNK   = 32'(CHUNK_BYTES);
  localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t state, state_nx;
  logic [31:0] base_q, size_q, addr_q, rem_q;
  logic [3:0]  tag_q;
  logic        held_q, stop_pend_q, err_seen_q;
  logic [CMD_BTT_W-1:0] btt;
  logic [CMD_W-1:0]     cmd_word;
  logic last_chunk, cmd_hs, sts_beat, sts_fail, start_ok, stop_any, fail_any, wrap;

  assign btt        = (rem_q > CHUNK) ? CHUNK[CMD_BTT_W-1:0] : rem_q[CMD_BTT_W-1:0];
  assign last_chunk = (rem_q <= CHUNK);
  assign cmd_hs     = m_axis_cmd_tvalid && m_axis_cmd_tready;
  assign sts_beat   = s_axis_sts_tvalid;
  assign sts_fail   = sts_beat && (!s_axis_sts_tdata[STS_OKAY_BIT] || s_axis_sts_tdata[STS_SLVERR_BIT]
                                   || s_axis_sts_tdata[STS_DECERR_BIT] || s_axis_sts_tdata[STS_INTERR_BIT]);
  assign start_ok   = start && (cap_size != 32'd0);
  assign stop_any   = stop_pend_q || stop;
  assign fail_any   = err_seen_q || sts_fail;
  assign wrap       = continuous && !stop_any;

  assign s_axis_sts_tready = 1'b1;

  s2mm_cmd_pack u_pack (
    .btt  (btt),
    .addr (addr_q),
    .tag  (tag_q),
    .cmd  (cmd_word)
  );

  assign m_axis_cmd_tdata = m_axis_cmd_tvalid ? cmd_word : '0;

  always_ff @(posedge axis_st_clk or negedge axis_st_rstb) begin
    if (!axis_st_rstb) state <= ST_IDLE;
    else               state <= state_nx;
  end

  // A presented command (tvalid high, tready low) must complete before any exit from ISSUE.
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  if (start_ok) state_nx = ST_ISSUE;
        ST_ISSUE: begin
          if (cmd_hs) begin
            if (fail_any)                               state_nx = ST_ERROR;
            else if ((last_chunk && !wrap) || stop_any) state_nx = ST_DRAIN;
          end else if (!m_axis_cmd_tvalid) begin
            if (fail_any)      state_nx = ST_ERROR;
            else if (stop_any) state_nx = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (sts_fail)                  state_nx = ST_ERROR;
          else if (outstanding == 4'd0)  state_nx = ST_DONE;
        end
        ST_DONE:  state_nx = ST_IDLE;
        ST_ERROR: state_nx = ST_ERROR;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
    err  = (state == ST_ERROR);
    m_axis_cmd_tvalid = (state == ST_ISSUE) &&
                        (held_q || ((outstanding < MAX_OUT) && !stop_pend_q && !err_seen_q));
  end

  always_ff @(posedge axis_st_clk or negedge axis_st_rstb) begin
    if (!axis_st_rstb) begin
      base_q      <= '0;
      size_q      <= '0;
      addr_q      <= '0;
      rem_q       <= '0;
      tag_q       <= '0;
      held_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      err_seen_q  <= 1'b0;
      err_status  <= '0;
      pass_count  <= '0;
      outstanding <= '0;
    end else if (clear) begin
      tag_q       <= '0;
      held_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      err_seen_q  <= 1'b0;
      err_status  <= '0;
      pass_count  <= '0;
      outstanding <= '0;
    end else begin
      held_q <= m_axis_cmd_tvalid && !m_axis_cmd_tready;

      unique case ({cmd_hs, sts_beat})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   if (outstanding != 4'd0) outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase

      if (state == ST_IDLE && start_ok) begin
        base_q      <= base_addr;
        size_q      <= cap_size;
        addr_q      <= base_addr;
        rem_q       <= cap_size;
        tag_q       <= '0;
        stop_pend_q <= 1'b0;
      end

      if (state == ST_ISSUE && stop) stop_pend_q <= 1'b1;

      if (cmd_hs) begin
        tag_q <= tag_q + 4'd1;
        if (last_chunk) begin
          pass_count <= pass_count + 16'd1;
          if (wrap) begin
            addr_q <= base_q;
            rem_q  <= size_q;
          end else begin
            addr_q <= addr_q + {9'd0, btt};
            rem_q  <= rem_q - {9'd0, btt};
          end
        end else begin
          addr_q <= addr_q + {9'd0, btt};
          rem_q  <= rem_q - {9'd0, btt};
        end
      end

      if (sts_fail && !err_seen_q && (state == ST_ISSUE || state == ST_DRAIN)) begin
        err_seen_q <= 1'b1;
        err_status <= s_axis_sts_tdata;
      end
    end
  end

endmodule

// File: tb/tb_s2mm_cmd_sched.sv
// Scoreboard bench for s2mm_cmd_sched: expected commands queued by the stimulus,
// popped by a monitor on each handshake; a responder model returns status beats.
module tb_s2mm_cmd_sched;

  logic        clk = 1'b0;
  logic        rstb;
  logic        start, stop, clear, continuous;
  logic [31:0] base_addr, cap_size;
  logic [71:0] tdata;
  logic        tvalid, tready;
  logic [7:0]  sts_tdata;
  logic        sts_tvalid, sts_tready;
  logic        busy, done, err;
  logic [7:0]  err_status;
  logic [15:0] pass_count;
  logic [3:0]  outstanding;

  s2mm_cmd_sched #(.CHUNK_BYTES(4096), .MAX_OUTSTANDING(4)) dut (
    .axis_st_clk       (clk),
    .axis_st_rstb      (rstb),
    .start             (start),
    .stop              (stop),
    .clear             (clear),
    .continuous        (continuous),
    .base_addr         (base_addr),
    .cap_size          (cap_size),
    .m_axis_cmd_tdata  (tdata),
    .m_axis_cmd_tvalid (tvalid),
    .m_axis_cmd_tready (tready),
    .s_axis_sts_tdata  (sts_tdata),
    .s_axis_sts_tvalid (sts_tvalid),
    .s_axis_sts_tready (sts_tready),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .err_status        (err_status),
    .pass_count        (pass_count),
    .outstanding       (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [3:0] tag;
  } sts_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [71:0] exp_q[$];
  sts_t        sts_q[$];
  int          cyc = 0;
  int          sts_dly = 5;
  bit          sts_en = 1'b1;
  int          fail_tag = -1;
  int          hs_count = 0;
  int          done_cnt = 0;
  logic [71:0] exp_cmd;
  sts_t        cur_sts;

  function automatic logic [71:0] mk_cmd(input logic [22:0] btt, input logic [31:0] addr,
                                         input logic [3:0] tag);
    return {4'h0, tag, addr, 1'b0, 1'b1, 6'h00, 1'b1, btt};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (rstb && tvalid && tready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_cmd: got 0x%0h, expected no command", tdata);
      end else begin
        exp_cmd = exp_q.pop_front();
        check("cmd", tdata, exp_cmd);
      end
      sts_q.push_back('{cyc + sts_dly, tdata[67:64]});
    end
    if (done) done_cnt++;
  end

  // Datamover status model: one beat per cycle once due.
  always @(posedge clk) begin
    #1;
    if (rstb && sts_en && sts_q.size() > 0 && sts_q[0].due <= cyc) begin
      cur_sts    = sts_q.pop_front();
      sts_tvalid = 1'b1;
      sts_tdata  = (int'(cur_sts.tag) == fail_tag) ? 8'h41 : {4'h8, cur_sts.tag};
    end else begin
      sts_tvalid = 1'b0;
      sts_tdata  = 8'h00;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_capture(input logic [31:0] base, input logic [31:0] size, input logic cont);
    base_addr  = base;
    cap_size   = size;
    continuous = cont;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int i = 0;
    while (busy && i < max_cyc) begin
      tick(1);
      i++;
    end
    check({name, "_idle_timeout"}, {71'd0, busy}, 72'd0);
  endtask

  task automatic push_lin(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back(mk_cmd(23'h1000, base + 32'(i) * 32'h1000, 4'(i)));
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_tvalid"},      {71'd0, tvalid}, 72'd0);
    check({name, "_tdata"},       tdata, 72'd0);
    check({name, "_busy"},        {71'd0, busy}, 72'd0);
    check({name, "_done"},        {71'd0, done}, 72'd0);
    check({name, "_err"},         {71'd0, err}, 72'd0);
    check({name, "_err_status"},  {64'd0, err_status}, 72'd0);
    check({name, "_pass_count"},  {56'd0, pass_count}, 72'd0);
    check({name, "_outstanding"}, {68'd0, outstanding}, 72'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, hs0, i;
    logic [71:0] snap;
    logic stable;

    rstb = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; continuous = 1'b0;
    base_addr = '0; cap_size = '0; tready = 1'b1;
    sts_tdata = '0; sts_tvalid = 1'b0;
    tick(2);
    check_zero_outputs("reset");
    rstb = 1'b1;
    tick(2);

    // Zero-size start is ignored.
    run_capture(32'h1000_0000, 32'h0, 1'b0);
    check("zero_size_ignored", {71'd0, busy}, 72'd0);

    // Single pass, 3 full chunks.
    exp_q.push_back(mk_cmd(23'h1000, 32'h1000_0000, 4'd0));
    exp_q.push_back(mk_cmd(23'h1000, 32'h1000_1000, 4'd1));
    exp_q.push_back(mk_cmd(23'h1000, 32'h1000_2000, 4'd2));
    d0 = done_cnt;
    run_capture(32'h1000_0000, 32'h3000, 1'b0);
    wait_idle("t1", 200);
    tick(2);
    check("t1_pass_count", {56'd0, pass_count}, 72'd1);
    check("t1_done_pulses", 72'(done_cnt - d0), 72'd1);
    check("t1_cmds_left", 72'(exp_q.size()), 72'd0);
    check("t1_outstanding", {68'd0, outstanding}, 72'd0);

    // Short last chunk.
    exp_q.push_back(mk_cmd(23'h1000, 32'h1000_0000, 4'd0));
    exp_q.push_back(mk_cmd(23'h1000, 32'h1000_1000, 4'd1));
    exp_q.push_back(mk_cmd(23'h0800, 32'h1000_2000, 4'd2));
    d0 = done_cnt;
    run_capture(32'h1000_0000, 32'h2800, 1'b0);
    wait_idle("t2", 200);
    tick(2);
    check("t2_pass_count", {56'd0, pass_count}, 72'd2);
    check("t2_done_pulses", 72'(done_cnt - d0), 72'd1);
    check("t2_cmds_left", 72'(exp_q.size()), 72'd0);

    // Backpressure hold, then credit limit with statuses withheld.
    sts_en = 1'b0;
    tready = 1'b0;
    push_lin(32'h3000_0000, 8);
    run_capture(32'h3000_0000, 32'h8000, 1'b0);
    snap   = tdata;
    stable = tvalid;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (tdata !== snap || tvalid !== 1'b1) stable = 1'b0;
    end
    check("t3_hold_stable", {71'd0, stable}, 72'd1);
    check("t3_held_cmd", snap, mk_cmd(23'h1000, 32'h3000_0000, 4'd0));
    tready = 1'b1;
    tick(20);
    check("t3_tvalid_blocked", {71'd0, tvalid}, 72'd0);
    check("t3_outstanding_full", {68'd0, outstanding}, 72'd4);
    check("t3_cmds_remaining", 72'(exp_q.size()), 72'd4);
    sts_en = 1'b1;
    wait_idle("t3", 300);
    tick(2);
    check("t3_pass_count", {56'd0, pass_count}, 72'd3);
    check("t3_cmds_left", 72'(exp_q.size()), 72'd0);

    // Continuous wrap, stop while the 5th command is presented but not accepted.
    exp_q.push_back(mk_cmd(23'h1000, 32'h4000_0000, 4'd0));
    exp_q.push_back(mk_cmd(23'h1000, 32'h4000_1000, 4'd1));
    exp_q.push_back(mk_cmd(23'h1000, 32'h4000_0000, 4'd2));
    exp_q.push_back(mk_cmd(23'h1000, 32'h4000_1000, 4'd3));
    exp_q.push_back(mk_cmd(23'h1000, 32'h4000_0000, 4'd4));
    d0  = done_cnt;
    hs0 = hs_count;
    run_capture(32'h4000_0000, 32'h2000, 1'b1);
    i = 0;
    while (hs_count - hs0 < 4 && i < 50) begin tick(1); i++; end
    tready = 1'b0;
    i = 0;
    while (!tvalid && i < 50) begin tick(1); i++; end
    check("t4_fifth_presented", {71'd0, tvalid}, 72'd1);
    stop = 1'b1;
    tick(1);
    stop   = 1'b0;
    tready = 1'b1;
    wait_idle("t4", 300);
    continuous = 1'b0;
    tick(2);
    check("t4_hs_total", 72'(hs_count - hs0), 72'd5);
    check("t4_pass_count", {56'd0, pass_count}, 72'd5);
    check("t4_done_pulses", 72'(done_cnt - d0), 72'd1);
    check("t4_cmds_left", 72'(exp_q.size()), 72'd0);

    // Failing status on tag 1; command 4 was already presented when it arrived.
    fail_tag = 1;
    push_lin(32'h5000_0000, 5);
    d0 = done_cnt;
    run_capture(32'h5000_0000, 32'h8000, 1'b0);
    i = 0;
    while (!err && i < 100) begin tick(1); i++; end
    check("t5_err", {71'd0, err}, 72'd1);
    tick(30);
    check("t5_err_status", {64'd0, err_status}, 72'h41);
    check("t5_cmds_left", 72'(exp_q.size()), 72'd0);
    check("t5_outstanding", {68'd0, outstanding}, 72'd0);
    check("t5_tvalid", {71'd0, tvalid}, 72'd0);
    check("t5_busy", {71'd0, busy}, 72'd1);
    check("t5_no_done", 72'(done_cnt - d0), 72'd0);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    fail_tag = -1;
    check_zero_outputs("t5_clear");

    // Simultaneous command and status at outstanding 2, then async reset mid-issue.
    sts_dly = 2;
    push_lin(32'h6000_0000, 16);
    hs0 = hs_count;
    run_capture(32'h6000_0000, 32'h1_0000, 1'b0);
    i = 0;
    while (hs_count - hs0 < 4 && i < 50) begin tick(1); i++; end
    check("t6_outstanding_simul", {68'd0, outstanding}, 72'd2);
    check("t6_tvalid", {71'd0, tvalid}, 72'd1);
    #2;
    rstb = 1'b0;
    #1;
    check_zero_outputs("t6_async_reset");
    exp_q.delete();
    sts_q.delete();
    tick(2);
    rstb = 1'b1;
    tick(2);
    check("t6_idle_after_reset", {71'd0, busy}, 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
